bcd_stopwatch: RTL and testbench

Four-digit BCD stopwatch counter that produces the 16-bit digit word for the four `char_7seg` display decoders. It replaces raw switch values as the source of `HEX3..HEX0` data: `BCD[15:12]` drives HEX3 and `BCD[3:0]` drives HEX0. A start/stop button toggles counting. A prescaler turns the board clock into count ticks. The block also supports clear and parallel load.

---
 rtl/bcd_stopwatch_pkg.sv | 27 ++
 rtl/bcd_digit.sv | 51 +++++
 rtl/bcd_stopwatch.sv | 166 ++++++++++++++++
 tb/tb_bcd_stopwatch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_pkg.sv
// bcd_stopwatch_pkg
// Shared constants, types and helpers for the four-digit BCD stopwatch.
//   NUM_DIGITS   - number of decade digits in the display word
//   DIGIT_W      - bits per BCD digit
//   DIGIT_MAX    - largest legal decimal digit value
//   sw_state_e   - start/stop FSM state
//   bcd_sanitize - maps an out-of-range nibble (A..F) to 0 so digits always stay displayable
package bcd_stopwatch_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic {
    STOPPED = 1'b0,
    RUN     = 1'b1
  } sw_state_e;

  // A loaded nibble above 9 would blank the 7-segment decoder, so force it to 0.
  function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] nib);
    logic [DIGIT_W-1:0] res;
    res = (nib > DIGIT_MAX) ? '0 : nib;
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One registered decade counter (0..9) of the stopwatch carry chain.
// Ports:
//   CLOCK_50   - clock, rising edge
//   RESET      - asynchronous active-high reset, digit returns to 0
//   clear_i    - synchronous clear to 0 (highest priority)
//   load_i     - synchronous load of load_val_i (nibbles above 9 load as 0)
//   load_val_i - value to load
//   carry_i    - increment request from the lower digit (or the count tick for digit 0)
//   digit_o    - current digit value, always 0..9
//   carry_o    - increment request passed to the next digit (this digit wraps 9 -> 0)
module bcd_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               carry_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               carry_o
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = bcd_sanitize(load_val_i);
    end else if (carry_i) begin
      digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // The top only raises carry_i when no clear/load is pending, so the carry
  // chain never needs to see those controls.
  assign carry_o = carry_i & (digit_q == DIGIT_MAX);
  assign digit_o = digit_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
// Four-digit BCD stopwatch producing the digit word for the HEX3..HEX0 decoders.
// A start/stop button toggles between STOPPED and RUN; a prescaler derives the
// count tick from the board clock; CLEAR and LOAD override counting.
// Parameters:
//   TICK_DIV   - CLOCK_50 cycles per count tick (>= 2)
// Ports:
//   CLOCK_50   - clock, rising edge
//   RESET      - asynchronous active-high reset
//   START_STOP - asynchronous active-high button level
//   CLEAR      - synchronous clear of count and prescaler
//   LOAD       - synchronous load of LOAD_VAL, prescaler restarts
//   LOAD_VAL   - BCD load value, most significant digit in [15:12]
//   BCD        - current count, one nibble per digit
//   RUNNING    - high in the RUN state
//   TICK       - one-cycle pulse coincident with each displayed increment
//   WRAP       - one-cycle pulse coincident with the 9999 -> 0000 rollover
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500_000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        START_STOP,
  input  logic        CLEAR,
  input  logic        LOAD,
  input  logic [15:0] LOAD_VAL,
  output logic [15:0] BCD,
  output logic        RUNNING,
  output logic        TICK,
  output logic        WRAP
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Button path: two-flop synchronizer plus previous-value register
  // ---------------------------------------------------------------------------
  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic ss_edge;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ss_meta_q <= 1'b0;
      ss_sync_q <= 1'b0;
      ss_prev_q <= 1'b0;
    end else begin
      ss_meta_q <= START_STOP;
      ss_sync_q <= ss_meta_q;
      ss_prev_q <= ss_sync_q;
    end
  end

  // Rising edge only, so a held button toggles exactly once.
  assign ss_edge = ss_sync_q & ~ss_prev_q;

  // ---------------------------------------------------------------------------
  // Start/stop FSM; CLEAR and LOAD deliberately have no effect here
  // ---------------------------------------------------------------------------
  sw_state_e state_q;
  logic      running_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= STOPPED;
      running_q <= 1'b0;
    end else if (ss_edge) begin
      unique case (state_q)
        STOPPED: begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: begin
          state_q   <= STOPPED;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= STOPPED;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: advances only in RUN and holds its value while stopped, so a
  // resume finishes the partially elapsed period.
  // ---------------------------------------------------------------------------
  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick_due;
  logic              tick_inc;

  assign tick_due = (state_q == RUN) && (presc_q == PrescLast);
  // CLEAR/LOAD in a tick cycle drop the increment entirely.
  assign tick_inc = tick_due & ~CLEAR & ~LOAD;

  always_comb begin
    presc_d = presc_q;
    if (CLEAR || LOAD) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = tick_due ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit chain: ripple carry from digit 0 (least significant) upwards.
  // Each stage keeps its own scalar carry signals so the chain is not one
  // self-referencing vector.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic cin;
    logic cout;

    if (i == 0) begin : g_first
      assign cin = tick_inc;
    end else begin : g_chain
      assign cin = g_digit[i-1].cout;
    end

    bcd_digit u_digit (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .clear_i    (CLEAR),
      .load_i     (LOAD),
      .load_val_i (LOAD_VAL[i*DIGIT_W +: DIGIT_W]),
      .carry_i    (cin),
      .digit_o    (BCD[i*DIGIT_W +: DIGIT_W]),
      .carry_o    (cout)
    );
  end

  // Carry out of the top digit means 9999 is about to roll to 0000.
  logic wrap_inc;
  assign wrap_inc = g_digit[NUM_DIGITS-1].cout;

  // ---------------------------------------------------------------------------
  // Registered status pulses, aligned with the cycle BCD shows the new value
  // ---------------------------------------------------------------------------
  logic tick_q, wrap_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= tick_inc;
      wrap_q <= wrap_inc;
    end
  end

  assign RUNNING = running_q;
  assign TICK    = tick_q;
  assign WRAP    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch
// Directed scenarios with literal expectations, then a randomized run, all
// compared every cycle against a decimal-integer model of the stopwatch.
module tb_bcd_stopwatch;

  localparam int unsigned TickDiv = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss  = 1'b0;
  logic        clr = 1'b0;
  logic        ld  = 1'b0;
  logic [15:0] ld_val = 16'h0000;
  logic [15:0] bcd;
  logic        running, tick, wrap;

  bcd_stopwatch #(
    .TICK_DIV (TickDiv)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .START_STOP (ss),
    .CLEAR      (clr),
    .LOAD       (ld),
    .LOAD_VAL   (ld_val),
    .BCD        (bcd),
    .RUNNING    (running),
    .TICK       (tick),
    .WRAP       (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: count kept as a plain decimal integer 0..9999,
  // elapsed cycles of the current tick period, run flag, and the last three
  // button samples (the edge is seen two clocks after the first high sample).
  // ---------------------------------------------------------------------------
  int m_count;
  int m_phase;
  bit m_run, m_tick, m_wrap;
  bit h1, h2, h3;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [15:0] val);
    int v;
    int nib;
    v = 0;
    for (int k = 3; k >= 0; k--) begin
      nib = int'((val >> (k * 4)) & 16'h000f);
      if (nib > 9) nib = 0;
      v = v * 10 + nib;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_phase = 0;
    m_run   = 1'b0;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
    h1 = 1'b0;
    h2 = 1'b0;
    h3 = 1'b0;
  endtask

  task automatic model_step();
    bit edge_now;
    bit due;
    edge_now = h2 & ~h3;
    due      = m_run && (m_phase == TickDiv - 1);
    m_tick   = 1'b0;
    m_wrap   = 1'b0;
    if (clr) begin
      m_count = 0;
      m_phase = 0;
    end else if (ld) begin
      m_count = load_value(ld_val);
      m_phase = 0;
    end else if (due) begin
      m_count = (m_count + 1) % 10000;
      m_phase = 0;
      m_tick  = 1'b1;
      m_wrap  = (m_count == 0);
    end else if (m_run) begin
      m_phase++;
    end
    if (edge_now) m_run = !m_run;
    h3 = h2;
    h2 = h1;
    h1 = ss;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
  end

  initial forever begin
    @(posedge rst);
    model_reset();
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("model_bcd", 32'(bcd), 32'(to_bcd(m_count)));
      check("model_running", 32'(running), 32'(m_run));
      check("model_tick", 32'(tick), 32'(m_tick));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 4 * TickDiv);
    check("tick_seen", 32'(tick), 32'd1);
  endtask

  initial begin
    int cnt;
    model_reset();

    // 1. Reset
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick) cnt++;
    end
    check("idle_ticks", 32'(cnt), 32'd0);
    check("idle_bcd", 32'(bcd), 32'h0);
    check("idle_running", 32'(running), 32'h0);

    // 2. Start and count: button held for 10 cycles
    ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("start_lat2", 32'(running), 32'd0);
    @(negedge clk);
    check("start_lat3", 32'(running), 32'd1);
    cnt = 0;
    while (bcd !== 16'h0010 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 7) ss = 1'b0;
    end
    check("ten_ticks_cycles", 32'(cnt), 32'd40);
    check("single_toggle", 32'(running), 32'd1);

    // 3. Stop with the prescaler frozen at 2, then resume
    wait_tick();
    check("bcd_0011", 32'(bcd), 32'h0011);
    repeat (3) @(negedge clk);
    ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ss = 1'b0;
    @(negedge clk);
    check("stopped", 32'(running), 32'd0);
    repeat (8) @(negedge clk);
    check("frozen_bcd", 32'(bcd), 32'h0012);
    check("still_stopped", 32'(running), 32'd0);
    ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ss = 1'b0;
    @(negedge clk);
    check("resumed", 32'(running), 32'd1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tick && cnt < 20);
    check("resume_tick_cycles", 32'(cnt), 32'd2);
    check("resume_bcd", 32'(bcd), 32'h0013);

    // 4. Load 9998 and wrap
    ld = 1'b1;
    ld_val = 16'h9998;
    @(negedge clk);
    ld = 1'b0;
    check("load_9998", 32'(bcd), 32'h9998);
    wait_tick();
    check("bcd_9999", 32'(bcd), 32'h9999);
    check("no_wrap_9999", 32'(wrap), 32'd0);
    wait_tick();
    check("wrap_bcd", 32'(bcd), 32'h0000);
    check("wrap_pulse", 32'(wrap), 32'd1);
    @(negedge clk);
    check("wrap_one_cycle", 32'(wrap), 32'd0);
    check("tick_one_cycle", 32'(tick), 32'd0);

    // 5. Invalid nibbles load as 0
    ld = 1'b1;
    ld_val = 16'hA9F3;
    @(negedge clk);
    ld = 1'b0;
    check("invalid_load", 32'(bcd), 32'h0903);

    // 6. CLEAR in a tick cycle together with a start/stop edge
    wait_tick();
    @(negedge clk);
    ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ss = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_tick_bcd", 32'(bcd), 32'h0000);
    check("clr_tick_suppressed", 32'(tick), 32'd0);
    check("clr_edge_toggles", 32'(running), 32'd0);

    // RESET mid-count, checked without waiting for a clock edge
    ss = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ss = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_counting", 32'(bcd != 16'h0000), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bcd", 32'(bcd), 32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    check("async_rst_tick", 32'(tick), 32'h0);
    check("async_rst_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0) ss = ~ss;
      clr = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0: ld_val = 16'($urandom);
        1: ld_val = 16'h9990 | 16'($urandom_range(0, 9));
        default: ld_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
    end
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    ld  = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
